tmds_encoder: RTL and testbench

Single-channel DVI 1.0 TMDS 8b/10b encoder running in the 25 MHz pixel clock domain. It sits directly downstream of the pixel/timing generator and consumes one colour component (`r`, `g` or `b`) plus `de`, `hsync` and `vsync`. It produces one 10-bit DC-balanced symbol per pixel clock for the 125 MHz 10:1 serializer. The blue instance carries hsync/vsync on `c0`/`c1`; the red and green instances tie `c0`/`c1` to 0.

---
 rtl/tmds_encoder.sv | 128 ++++++++++++
 tb/tb_tmds_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder: transition-minimising stage followed by a
// DC-balancing stage, one 10-bit symbol per pixel clock with two cycles of latency.
module tmds_encoder (
    input  logic              clk,
    input  logic              rst,
    input  logic              de,
    input  logic              c0,
    input  logic              c1,
    input  logic [7:0]        d,
    output logic [9:0]        q_out,
    output logic signed [4:0] disp
);

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m_next;
    logic [3:0] n1_next;

    logic [8:0] q_m_q;
    logic [3:0] n1_q;
    logic       de_q;
    logic       c0_q;
    logic       c1_q;

    logic [4:0] cnt;
    logic [4:0] cnt_next;
    logic [9:0] q_next;

    logic [4:0] n1_w;
    logic [4:0] n0_w;
    logic [4:0] diff_10;
    logic [4:0] diff_01;
    logic [4:0] two_q8;
    logic [4:0] two_nq8;
    logic       cnt_zero;
    logic       cnt_pos;
    logic       cnt_neg;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + {3'b000, d[i]};
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

        q_m_next    = '0;
        q_m_next[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m_next[i] = use_xnor ? ~(q_m_next[i-1] ^ d[i]) : (q_m_next[i-1] ^ d[i]);
        end
        q_m_next[8] = ~use_xnor;

        n1_next = '0;
        for (int i = 0; i < 8; i++) begin
            n1_next = n1_next + {3'b000, q_m_next[i]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_m_q <= '0;
            n1_q  <= '0;
            de_q  <= 1'b0;
            c0_q  <= 1'b0;
            c1_q  <= 1'b0;
        end else begin
            q_m_q <= q_m_next;
            n1_q  <= n1_next;
            de_q  <= de;
            c0_q  <= c0;
            c1_q  <= c1;
        end
    end

    // Disparity arithmetic is plain 5-bit two's complement; the wrap is harmless
    // because the running count never leaves -8..+8.
    always_comb begin
        n1_w     = {1'b0, n1_q};
        n0_w     = 5'd8 - n1_w;
        diff_10  = n1_w - n0_w;
        diff_01  = n0_w - n1_w;
        two_q8   = {3'b000, q_m_q[8], 1'b0};
        two_nq8  = {3'b000, ~q_m_q[8], 1'b0};
        cnt_zero = (cnt == 5'd0);
        cnt_neg  = cnt[4];
        cnt_pos  = !cnt[4] && !cnt_zero;

        q_next   = CTRL_00;
        cnt_next = '0;

        if (!de_q) begin
            case ({c1_q, c0_q})
                2'b00:   q_next = CTRL_00;
                2'b01:   q_next = CTRL_01;
                2'b10:   q_next = CTRL_10;
                default: q_next = CTRL_11;
            endcase
            cnt_next = '0;
        end else if (cnt_zero || (n1_q == 4'd4)) begin
            q_next   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_next = cnt + (q_m_q[8] ? diff_10 : diff_01);
        end else if ((cnt_pos && (n1_q > 4'd4)) || (cnt_neg && (n1_q < 4'd4))) begin
            q_next   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_next = cnt + two_q8 + diff_01;
        end else begin
            q_next   = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_next = cnt - two_nq8 + diff_10;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_out <= CTRL_00;
            cnt   <= '0;
        end else begin
            q_out <= q_next;
            cnt   <= cnt_next;
        end
    end

    assign disp = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Testbench for tmds_encoder: directed DVI vectors plus a randomized soak scored
// against an integer reference encoder, with decode-back and disparity range checks.
module tb_tmds_encoder;

    logic              clk;
    logic              rst;
    logic              de;
    logic              c0;
    logic              c1;
    logic [7:0]        d;
    logic [9:0]        q_out;
    logic signed [4:0] disp;

    int checkCount;
    int errorCount;
    int modelCnt;

    typedef struct packed {
        logic [9:0] q;
        int         dispVal;
        logic       deVal;
        logic [1:0] cVal;
        logic [7:0] dVal;
        logic       directed;
    } exp_t;

    exp_t expQ[$];

    tmds_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .de    (de),
        .c0    (c0),
        .c1    (c1),
        .d     (d),
        .q_out (q_out),
        .disp  (disp)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    // Reference encoder written from the DVI rules using integer arithmetic.
    function automatic logic [9:0] modelEncode(input logic deIn, input logic [1:0] cIn,
                                               input logic [7:0] dIn);
        int   ones;
        int   n1;
        int   n0;
        logic useXnor;
        logic [8:0] qm;
        logic [9:0] sym;
        if (!deIn) begin
            modelCnt = 0;
            case (cIn)
                2'b00:   sym = 10'h354;
                2'b01:   sym = 10'h0AB;
                2'b10:   sym = 10'h154;
                default: sym = 10'h2AB;
            endcase
            return sym;
        end
        ones    = $countones(dIn);
        useXnor = (ones > 4) || (ones == 4 && dIn[0] == 1'b0);
        qm      = '0;
        qm[0]   = dIn[0];
        for (int i = 1; i < 8; i++)
            qm[i] = useXnor ? !(qm[i-1] ^ dIn[i]) : (qm[i-1] ^ dIn[i]);
        qm[8] = !useXnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (modelCnt == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            modelCnt = modelCnt + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((modelCnt > 0 && n1 > n0) || (modelCnt < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            modelCnt = modelCnt + 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            modelCnt = modelCnt - 2 * int'(!qm[8]) + (n1 - n0);
        end
        return sym;
    endfunction

    // Receiver-side decode, independent of how the encoder chose its branch.
    function automatic logic [7:0] decodeData(input logic [9:0] s);
        logic [7:0] x;
        logic [7:0] r;
        x    = s[9] ? ~s[7:0] : s[7:0];
        r[0] = x[0];
        for (int i = 1; i < 8; i++)
            r[i] = s[8] ? (x[i] ^ x[i-1]) : !(x[i] ^ x[i-1]);
        return r;
    endfunction

    function automatic int decodeCtrl(input logic [9:0] s);
        case (s)
            10'b1101010100: return 0;
            10'b0010101011: return 1;
            10'b0101010100: return 2;
            10'b1010101011: return 3;
            default:        return -1;
        endcase
    endfunction

    // Called on a falling edge: score the symbol due now, then drive the next input.
    task automatic stepCycle(input exp_t e);
        exp_t o;
        int   dv;
        o  = expQ.pop_front();
        dv = int'($signed(disp));
        checkOutput(o.directed ? "dir_q_out" : "q_out", int'(q_out), int'(o.q));
        checkOutput(o.directed ? "dir_disp" : "disp", dv, o.dispVal);
        checkOutput("disp_range", int'(dv >= -8 && dv <= 8), 1);
        if (o.deVal)
            checkOutput("decode_data", int'(decodeData(q_out)), int'(o.dVal));
        else
            checkOutput("decode_ctrl", decodeCtrl(q_out), int'(o.cVal));
        de = e.deVal;
        c1 = e.cVal[1];
        c0 = e.cVal[0];
        d  = e.dVal;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic deIn, input logic [1:0] cIn, input logic [7:0] dIn);
        exp_t e;
        e.q        = modelEncode(deIn, cIn, dIn);
        e.dispVal  = modelCnt;
        e.deVal    = deIn;
        e.cVal     = cIn;
        e.dVal     = dIn;
        e.directed = 1'b0;
        stepCycle(e);
    endtask

    // Directed vectors carry literal expectations; the model is still advanced so
    // that later random traffic continues from the right disparity.
    task automatic applyDirected(input logic deIn, input logic [1:0] cIn, input logic [7:0] dIn,
                                 input logic [9:0] qExp, input int dispExp);
        exp_t e;
        e.q        = modelEncode(deIn, cIn, dIn);
        e.q        = qExp;
        e.dispVal  = dispExp;
        e.deVal    = deIn;
        e.cVal     = cIn;
        e.dVal     = dIn;
        e.directed = 1'b1;
        modelCnt   = dispExp;
        stepCycle(e);
    endtask

    task automatic restartModel();
        exp_t e;
        expQ.delete();
        modelCnt   = 0;
        e.q        = 10'h354;
        e.dispVal  = 0;
        e.deVal    = 1'b0;
        e.cVal     = 2'b00;
        e.dVal     = 8'h00;
        e.directed = 1'b1;
        expQ.push_back(e);
        expQ.push_back(e);
    endtask

    task automatic randomSoak(input int cycles);
        logic       deIn;
        logic [1:0] cIn;
        logic [7:0] dIn;
        for (int i = 0; i < cycles; i++) begin
            deIn = ($urandom_range(0, 7) != 0);
            cIn  = 2'($urandom_range(0, 3));
            dIn  = 8'($urandom);
            applyStimulus(deIn, cIn, dIn);
        end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        modelCnt   = 0;
        rst = 1'b0;
        de  = 1'b0;
        c0  = 1'b0;
        c1  = 1'b0;
        d   = 8'h00;

        repeat (3) @(negedge clk);
        checkOutput("init_q_out", int'(q_out), 10'h354);
        checkOutput("init_disp", int'($signed(disp)), 0);
        rst = 1'b1;
        restartModel();

        applyDirected(1'b0, 2'b00, 8'($urandom), 10'h354, 0);
        applyDirected(1'b0, 2'b01, 8'($urandom), 10'h0AB, 0);
        applyDirected(1'b0, 2'b10, 8'($urandom), 10'h154, 0);
        applyDirected(1'b0, 2'b11, 8'($urandom), 10'h2AB, 0);
        applyDirected(1'b1, 2'($urandom), 8'h00, 10'h100, -8);
        applyDirected(1'b1, 2'($urandom), 8'h00, 10'h3FF, 2);
        applyDirected(1'b1, 2'($urandom), 8'h00, 10'h100, -6);
        applyDirected(1'b0, 2'b00, 8'hA5, 10'h354, 0);
        applyDirected(1'b1, 2'b11, 8'hFF, 10'h200, -8);
        applyDirected(1'b0, 2'b00, 8'h00, 10'h354, 0);
        applyDirected(1'b1, 2'b00, 8'h00, 10'h100, -8);
        applyDirected(1'b0, 2'b00, 8'h00, 10'h354, 0);
        applyDirected(1'b1, 2'b00, 8'h00, 10'h100, -8);

        randomSoak(5000);

        // Asynchronous reset in the middle of active video, away from any clock edge.
        de = 1'b1;
        #5 rst = 1'b0;
        #1;
        checkOutput("rst_async_q_out", int'(q_out), 10'h354);
        checkOutput("rst_async_disp", int'($signed(disp)), 0);
        @(negedge clk);
        checkOutput("rst_hold_q_out", int'(q_out), 10'h354);
        rst = 1'b1;
        restartModel();
        applyDirected(1'b0, 2'b00, 8'($urandom), 10'h354, 0);
        applyDirected(1'b0, 2'b00, 8'($urandom), 10'h354, 0);
        applyDirected(1'b1, 2'b00, 8'hFF, 10'h200, -8);

        randomSoak(5000);
        applyStimulus(1'b0, 2'b00, 8'h00);
        applyStimulus(1'b0, 2'b00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
